reg_wr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared register-file write port of the URCPU datapath.
- The write port is the bank of dff_sr storage elements behind it.
- Up to NREQ requesters (e.g. ALU writeback, load unit, CSR/debug path) each post a write. The block grants one per cycle and drives a registered write strobe, address and data onto the bank.
- A global hold input freezes granting while the pipeline stalls.

---
 rtl/reg_wr_arbiter.sv | 112 +++++++++++
 tb/tb_reg_wr_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_wr_arbiter.sv
// rtl/reg_wr_arbiter.sv - round-robin arbiter driving the shared register-file write port
module reg_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [ID_W-1:0]          gnt_id,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data
);

  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0]   eligible;
  logic              found;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   cand;
  logic [NREQ-1:0]   sel_onehot;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  int                idx;

  // The last grant masks its requester for one cycle so it can drop or refresh req.
  always_comb begin
    eligible = req & ~gnt_q;
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = ID_W'(idx);
      for (int i = 0; i < NREQ; i++) begin
        if (!found && cand == ID_W'(i) && eligible[i]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    sel_addr   = '0;
    sel_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == ID_W'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_addr      = addr[i*ADDR_W +: ADDR_W];
        sel_data      = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Hold and idle cycles keep ptr and the last written address/data.
  always_comb begin
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    gnt_id_d  = gnt_id_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    if (!hold && found) begin
      gnt_d     = sel_onehot;
      wr_en_d   = 1'b1;
      gnt_id_d  = sel;
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      ptr_d     = (sel == ID_W'(NREQ-1)) ? '0 : sel + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb/tb_reg_wr_arbiter.sv - scoreboard bench for reg_wr_arbiter with directed vectors
module tb_reg_wr_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   hold;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [ID_W-1:0]        gnt_id;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;

  typedef struct {
    string             name;
    logic [NREQ-1:0]   gnt;
    logic              wr_en;
    logic              chk_id;
    logic [ID_W-1:0]   id;
    logic              chk_wr;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_wr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .req     (req),
    .addr    (addr),
    .wdata   (wdata),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = (gnt === e.gnt) && (wr_en === e.wr_en);
      if (e.chk_id && gnt_id !== e.id) ok = 1'b0;
      if (e.chk_wr && (wr_addr !== e.waddr || wr_data !== e.wdat)) ok = 1'b0;
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: got gnt=%b wr_en=%b id=%0d addr=%0d data=%h, want gnt=%b wr_en=%b id=%0d addr=%0d data=%h",
                 e.name, gnt, wr_en, gnt_id, wr_addr, wr_data, e.gnt, e.wr_en, e.id, e.waddr, e.wdat);
      end
      n_checks++;
      if (wr_en !== (|gnt)) begin
        n_fail++;
        $display("FAIL %s_wr_en_or_gnt: got wr_en=%b gnt=%b, want wr_en=%b", e.name, wr_en, gnt, |gnt);
      end
    end
  end

  task automatic cyc(input string name, input logic [NREQ-1:0] g, input logic we,
                     input logic ci, input logic [ID_W-1:0] id,
                     input logic cw, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = name; e.gnt = g; e.wr_en = we; e.chk_id = ci; e.id = id;
    e.chk_wr = cw; e.waddr = wa; e.wdat = wd;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    req   = 4'b1111;
    addr  = {3'd4, 3'd3, 3'd2, 3'd1};
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};

    cyc("reset0", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 3'd0, 8'h00);
    cyc("reset1", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 3'd0, 8'h00);
    reset = 1'b0;

    cyc("rot0", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 3'd1, 8'h11);
    cyc("rot1", 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 8'h22);
    cyc("rot2", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 3'd3, 8'h33);
    cyc("rot3", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 3'd4, 8'h44);
    cyc("rot_wrap", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 3'd1, 8'h11);
    cyc("pre_hold", 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 8'h22);

    hold = 1'b1;
    cyc("hold0", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 3'd2, 8'h22);
    cyc("hold1", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 3'd2, 8'h22);
    cyc("hold2", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 3'd2, 8'h22);
    hold = 1'b0;
    cyc("post_hold", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 3'd3, 8'h33);
    req = 4'b0000;
    cyc("idle_keep", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 3'd3, 8'h33);

    req = 4'b0100;
    addr[2*ADDR_W +: ADDR_W]  = 3'd5;
    wdata[2*DATA_W +: DATA_W] = 8'hA5;
    cyc("single", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 3'd5, 8'hA5);
    req = 4'b0000;
    cyc("single_done", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 3'd5, 8'hA5);

    req = 4'b0001;
    cyc("mask0", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 3'd1, 8'h11);
    cyc("mask1", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 3'd1, 8'h11);
    cyc("mask2", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 3'd1, 8'h11);
    cyc("mask3", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 3'd1, 8'h11);

    req = 4'b1010;
    cyc("mid_pre", 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 8'h22);
    reset = 1'b1;
    cyc("mid_reset", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 3'd0, 8'h00);
    reset = 1'b0;
    cyc("mid_first", 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 8'h22);
    cyc("mid_second", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 3'd4, 8'h44);
    req = 4'b0000;
    cyc("mid_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 3'd4, 8'h44);

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
